// File: rtl/cpu_mem_pkg.sv
// Shared sizing and state encodings for the instruction cache and memory arbiter.
package cpu_mem_pkg;

  localparam int LINES = 256;
  localparam int AW    = 16;
  localparam int DW    = 16;
  localparam int IW    = $clog2(LINES);

  // Owner of the external memory port.
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    INSTR = 2'b01,
    DATA  = 2'b10
  } arb_state_t;

  // Instruction cache refill sequencer.
  typedef enum logic [1:0] {
    C_IDLE  = 2'b00,
    C_FETCH = 2'b01,
    C_FILL  = 2'b10
  } refill_state_t;

endpackage

// File: rtl/cpu_icache_ram.sv
// Line storage: LINES x {addr, data}, synchronous read, single write port.
// A write to the index being read is forwarded so the refilled line is
// visible to the very next lookup.
module cpu_icache_ram
  import cpu_mem_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            we,
  input  logic [IW-1:0]   waddr,
  input  logic [2*DW-1:0] wdata,
  input  logic [IW-1:0]   raddr,
  output logic [2*DW-1:0] rdata
);

  logic [2*DW-1:0] RAM [0:LINES-1];

  // Array write; the array itself carries no reset.
  always_ff @(posedge clk) begin
    if (we) RAM[waddr] <= wdata;
  end

  // Registered read with write-through forwarding; output clears on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    rdata <= '0;
    else if (we && waddr == raddr) rdata <= wdata;
    else                           rdata <= RAM[raddr];
  end

endmodule

// File: rtl/cpu_icache_mem_subsystem.sv
// Direct-mapped instruction cache with refill sequencer, plus a two-requester
// arbiter that shares one valid/ready memory port between cache refills and
// CPU data reads (data has priority, no preemption).
//
//   refill state | meaning
//   C_IDLE       | looking up; a miss latches the address and starts a refill
//   C_FETCH      | instruction request pending/in flight on the arbiter
//   C_FILL       | write {addr, word} into the line and mark it valid
//
//   arb state    | meaning
//   IDLE         | port free; pick data first, then instruction
//   INSTR        | refill transfer owns the port
//   DATA         | CPU data read owns the port
module cpu_icache_mem_subsystem
  import cpu_mem_pkg::*;
(
  input  logic            CLK,
  input  logic            RSTb,
  input  logic [AW-1:0]   request_address,
  output logic [2*DW-1:0] address_data,
  output logic            cache_miss,
  input  logic [AW-1:0]   data_memory_address,
  output logic [DW-1:0]   data_memory_data_out,
  input  logic [DW-1:0]   data_memory_in,
  input  logic            data_req,
  output logic            data_stall,
  output logic [AW-1:0]   memory_address,
  output logic [DW-1:0]   memory_data_out,
  input  logic [DW-1:0]   memory_data_in,
  output logic            memory_valid,
  input  logic            memory_ready
);

  logic [AW-1:0]    req_addr_q;
  logic             lookup_live;
  logic [LINES-1:0] line_valid;
  logic [2*DW-1:0]  ram_rdata;

  refill_state_t    c_state, c_next;
  logic [AW-1:0]    miss_addr;
  logic             instr_req;
  logic             fill_we;

  arb_state_t       a_state, a_next;
  logic             beat;
  logic [DW-1:0]    fetched_word;
  logic             instr_done;
  logic             data_done;

  cpu_icache_ram u_ram (
    .clk   (CLK),
    .rst_n (RSTb),
    .we    (fill_we),
    .waddr (miss_addr[IW-1:0]),
    .wdata ({miss_addr, fetched_word}),
    .raddr (request_address[IW-1:0]),
    .rdata (ram_rdata)
  );

  // Register the fetch address alongside the RAM read; lookup_live masks the
  // miss flag until the first post-reset lookup has actually happened.
  always_ff @(posedge CLK or negedge RSTb) begin
    if (!RSTb) begin
      req_addr_q  <= '0;
      lookup_live <= 1'b0;
    end else begin
      req_addr_q  <= request_address;
      lookup_live <= 1'b1;
    end
  end

  assign address_data = ram_rdata;
  assign cache_miss   = lookup_live &
                        (~line_valid[req_addr_q[IW-1:0]] |
                         (ram_rdata[2*DW-1:DW] != req_addr_q));

  // Valid bits sit outside the RAM so reset can clear them all at once.
  always_ff @(posedge CLK or negedge RSTb) begin
    if (!RSTb)        line_valid <= '0;
    else if (fill_we) line_valid[miss_addr[IW-1:0]] <= 1'b1;
  end

  // Refill state register.
  always_ff @(posedge CLK or negedge RSTb) begin
    if (!RSTb) c_state <= C_IDLE;
    else       c_state <= c_next;
  end

  // Freeze the miss address for the whole refill.
  always_ff @(posedge CLK or negedge RSTb) begin
    if (!RSTb)                                miss_addr <= '0;
    else if (c_state == C_IDLE && cache_miss) miss_addr <= req_addr_q;
  end

  // Refill next-state and request/write strobes.
  always_comb begin
    c_next    = c_state;
    instr_req = 1'b0;
    fill_we   = 1'b0;
    case (c_state)
      C_IDLE:  if (cache_miss) c_next = C_FETCH;
      C_FETCH: begin
        instr_req = 1'b1;
        if (instr_done) c_next = C_FILL;
      end
      C_FILL: begin
        fill_we = 1'b1;
        c_next  = C_IDLE;
      end
      default: c_next = C_IDLE;
    endcase
  end

  // Arbiter state, handshake phase and captured read data.
  // beat marks the cycle between E1 (ready seen) and E2 (data captured).
  always_ff @(posedge CLK or negedge RSTb) begin
    if (!RSTb) begin
      a_state              <= IDLE;
      beat                 <= 1'b0;
      memory_address       <= '0;
      fetched_word         <= '0;
      data_memory_data_out <= '0;
      instr_done           <= 1'b0;
      data_done            <= 1'b0;
    end else begin
      a_state    <= a_next;
      instr_done <= (a_state == INSTR) && beat;
      data_done  <= (a_state == DATA) && beat;
      if (a_state == IDLE || beat) beat <= 1'b0;
      else if (memory_ready)       beat <= 1'b1;
      if (a_state == IDLE && a_next == DATA)  memory_address <= data_memory_address;
      if (a_state == IDLE && a_next == INSTR) memory_address <= miss_addr;
      if (a_state == INSTR && beat) fetched_word         <= memory_data_in;
      if (a_state == DATA && beat)  data_memory_data_out <= memory_data_in;
    end
  end

  // Arbiter next-state and port drive. The done pulses block re-granting a
  // requester in the cycle it is still seeing its own completion.
  always_comb begin
    a_next          = a_state;
    memory_valid    = 1'b0;
    memory_data_out = '0;
    case (a_state)
      IDLE: begin
        if (data_req && !data_done)        a_next = DATA;
        else if (instr_req && !instr_done) a_next = INSTR;
      end
      INSTR: begin
        memory_valid = 1'b1;
        if (beat) a_next = IDLE;
      end
      DATA: begin
        memory_valid    = 1'b1;
        memory_data_out = data_memory_in;
        if (beat) a_next = IDLE;
      end
      default: a_next = IDLE;
    endcase
  end

  assign data_stall = data_req & ~data_done;

endmodule

// File: tb/tb_cpu_icache_mem_subsystem.sv
// Directed + randomized bench: a behavioural memory responder on the external
// port and a tag/valid model of the cache decide the expected hits, misses,
// transfer order and returned data.
module tb_cpu_icache_mem_subsystem;

  logic        CLK = 1'b0;
  logic        RSTb;
  logic [15:0] request_address;
  logic [31:0] address_data;
  logic        cache_miss;
  logic [15:0] data_memory_address;
  logic [15:0] data_memory_data_out;
  logic [15:0] data_memory_in;
  logic        data_req;
  logic        data_stall;
  logic [15:0] memory_address;
  logic [15:0] memory_data_out;
  logic [15:0] memory_data_in = 16'h0;
  logic        memory_valid;
  logic        memory_ready = 1'b0;

  int vectors = 0;
  int miscompares = 0;

  logic [15:0] mem [0:65535];
  logic [15:0] txn_addr [$];
  logic [15:0] txn_wdata [$];
  bit          ref_valid [0:255];
  logic [15:0] ref_tag [0:255];
  logic [15:0] pool [0:7];
  int          phase = 0;
  int          delay = 0;

  cpu_icache_mem_subsystem dut (
    .CLK                  (CLK),
    .RSTb                 (RSTb),
    .request_address      (request_address),
    .address_data         (address_data),
    .cache_miss           (cache_miss),
    .data_memory_address  (data_memory_address),
    .data_memory_data_out (data_memory_data_out),
    .data_memory_in       (data_memory_in),
    .data_req             (data_req),
    .data_stall           (data_stall),
    .memory_address       (memory_address),
    .memory_data_out      (memory_data_out),
    .memory_data_in       (memory_data_in),
    .memory_valid         (memory_valid),
    .memory_ready         (memory_ready)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // External memory: raise ready after a random wait, return mem[] in the
  // cycle after E1, optionally leave ready high one cycle past E2.
  always @(negedge CLK) begin
    if (!RSTb) begin
      phase        = 0;
      delay        = 0;
      memory_ready = 1'b0;
    end else begin
      case (phase)
        0: if (memory_valid) begin
          if (delay == 0) begin
            memory_ready = 1'b1;
            phase        = 1;
          end else delay--;
        end
        1: begin
          check("valid_hold", 32'(memory_valid), 32'd1);
          txn_addr.push_back(memory_address);
          txn_wdata.push_back(memory_data_out);
          memory_data_in = mem[memory_address];
          memory_ready   = 1'($urandom_range(0, 1));
          phase          = 2;
        end
        2: begin
          check("valid_drop", 32'(memory_valid), 32'd0);
          memory_data_in = 16'($urandom);
          memory_ready   = 1'($urandom_range(0, 1));
          phase          = 3;
        end
        default: begin
          memory_ready = 1'b0;
          delay        = int'($urandom_range(0, 2));
          phase        = 0;
        end
      endcase
    end
  end

  task automatic wait_miss_clear();
    int n = 0;
    while (cache_miss && n < 80) begin
      @(negedge CLK);
      n++;
    end
    check("miss_clear", 32'(cache_miss), 32'd0);
  endtask

  task automatic fetch(input logic [15:0] a);
    bit hit;
    int base;
    hit  = ref_valid[a[7:0]] && (ref_tag[a[7:0]] == a);
    base = txn_addr.size();
    request_address = a;
    @(negedge CLK);
    check("fetch_miss", 32'(cache_miss), 32'(!hit));
    wait_miss_clear();
    check("line_data", address_data, {a, mem[a]});
    repeat (3) @(negedge CLK);
    check("refill_count", 32'(txn_addr.size() - base), hit ? 32'd0 : 32'd1);
    if (!hit && txn_addr.size() > base) check("refill_addr", 32'(txn_addr[base]), 32'(a));
    ref_valid[a[7:0]] = 1'b1;
    ref_tag[a[7:0]]   = a;
  endtask

  task automatic data_start(input logic [15:0] a, input logic [15:0] wd);
    data_memory_address = a;
    data_memory_in      = wd;
    data_req            = 1'b1;
    #1;
    check("stall_rise", 32'(data_stall), 32'd1);
  endtask

  task automatic data_wait();
    int n = 0;
    while (data_stall && n < 80) begin
      @(negedge CLK);
      n++;
    end
    check("stall_fall", 32'(data_stall), 32'd0);
  endtask

  task automatic expect_txn(input string tag, input int base, input int k,
                            input logic [15:0] a, input logic [15:0] wd);
    if (txn_addr.size() > base + k) begin
      check({tag, "_addr"}, 32'(txn_addr[base + k]), 32'(a));
      check({tag, "_wdata"}, 32'(txn_wdata[base + k]), 32'(wd));
    end
  endtask

  initial begin
    int base;
    int n;
    logic [15:0] a;
    logic [15:0] wd;

    for (int i = 0; i < 65536; i++) mem[i] = 16'($urandom);
    mem[0] = 16'h1234;
    for (int i = 0; i < 256; i++) begin
      ref_valid[i] = 1'b0;
      ref_tag[i]   = 16'h0;
    end
    pool[0] = 16'h0000; pool[1] = 16'h0002; pool[2] = 16'h0004; pool[3] = 16'h0005;
    pool[4] = 16'h0105; pool[5] = 16'h0205; pool[6] = 16'h01FF; pool[7] = 16'hABCD;

    RSTb                = 1'b0;
    request_address     = 16'h0;
    data_memory_address = 16'h0;
    data_memory_in      = 16'h0;
    data_req            = 1'b0;
    #1;
    check("rst_mem_valid", 32'(memory_valid), 32'd0);
    check("rst_stall", 32'(data_stall), 32'd0);
    check("rst_miss", 32'(cache_miss), 32'd0);
    check("rst_addr_data", address_data, 32'd0);
    check("rst_data_out", 32'(data_memory_data_out), 32'd0);
    check("rst_mem_addr", 32'(memory_address), 32'd0);
    repeat (2) @(negedge CLK);
    #2 RSTb = 1'b1;

    // cold fetch, sequential fetches, re-hit
    fetch(16'h0000);
    check("cold_line", address_data, 32'h0000_1234);
    fetch(16'h0002);
    fetch(16'h0004);
    fetch(16'h0002);

    // conflict on index 5
    fetch(16'h0005);
    fetch(16'h0105);
    fetch(16'h0005);

    // data and miss arrive together: data goes first
    request_address = 16'h0033;
    @(negedge CLK);
    check("prio_miss", 32'(cache_miss), 32'd1);
    base = txn_addr.size();
    wd   = 16'($urandom);
    data_start(16'h0200, wd);
    data_wait();
    check("prio_data_out", 32'(data_memory_data_out), 32'(mem[16'h0200]));
    check("prio_refill_pending", 32'(cache_miss), 32'd1);
    data_req = 1'b0;
    wait_miss_clear();
    check("prio_line", address_data, {16'h0033, mem[16'h0033]});
    repeat (2) @(negedge CLK);
    check("prio_count", 32'(txn_addr.size() - base), 32'd2);
    expect_txn("prio_first", base, 0, 16'h0200, wd);
    expect_txn("prio_second", base, 1, 16'h0033, 16'h0000);
    ref_valid[8'h33] = 1'b1;
    ref_tag[8'h33]   = 16'h0033;

    // data request while a refill is in flight waits for it
    request_address = 16'h0044;
    base = txn_addr.size();
    n = 0;
    while (!memory_valid && n < 40) begin
      @(negedge CLK);
      n++;
    end
    check("inflight_valid", 32'(memory_valid), 32'd1);
    check("inflight_addr", 32'(memory_address), 32'h0044);
    wd = 16'($urandom);
    data_start(16'h03FF, wd);
    data_wait();
    check("during_refill_line_done", 32'(cache_miss), 32'd0);
    check("during_refill_data_out", 32'(data_memory_data_out), 32'(mem[16'h03FF]));
    data_req = 1'b0;
    repeat (2) @(negedge CLK);
    check("during_refill_count", 32'(txn_addr.size() - base), 32'd2);
    expect_txn("during_refill_first", base, 0, 16'h0044, 16'h0000);
    expect_txn("during_refill_second", base, 1, 16'h03FF, wd);
    check("during_refill_line", address_data, {16'h0044, mem[16'h0044]});
    ref_valid[8'h44] = 1'b1;
    ref_tag[8'h44]   = 16'h0044;

    // randomized mix of fetches and idle data reads
    repeat (24) begin
      if ($urandom_range(0, 3) != 0) fetch(pool[$urandom_range(0, 7)]);
      else begin
        a    = 16'($urandom);
        wd   = 16'($urandom);
        base = txn_addr.size();
        data_start(a, wd);
        data_wait();
        check("rand_data_out", 32'(data_memory_data_out), 32'(mem[a]));
        data_req = 1'b0;
        repeat (2) @(negedge CLK);
        check("rand_data_count", 32'(txn_addr.size() - base), 32'd1);
        expect_txn("rand_data", base, 0, a, wd);
      end
    end

    // reset in the middle of a refill
    request_address = 16'h0077;
    n = 0;
    while (!memory_valid && n < 40) begin
      @(negedge CLK);
      n++;
    end
    check("rstmid_inflight", 32'(memory_valid), 32'd1);
    #2 RSTb = 1'b0;
    #1;
    check("rstmid_valid", 32'(memory_valid), 32'd0);
    check("rstmid_miss", 32'(cache_miss), 32'd0);
    check("rstmid_addr_data", address_data, 32'd0);
    check("rstmid_mem_addr", 32'(memory_address), 32'd0);
    for (int i = 0; i < 256; i++) ref_valid[i] = 1'b0;
    request_address = 16'h0002;
    repeat (2) @(negedge CLK);
    #2 RSTb = 1'b1;
    fetch(16'h0002);
    fetch(16'h0077);
    fetch(16'h0000);
    fetch(16'h0002);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
